// File: rtl/seq_alu.sv
// seq_alu: multi-cycle integer ALU; MUL runs as an iterative shift-add, DIV as a restoring divider.
// Single-cycle ops, illegal ops and divide-by-zero complete straight from IDLE.
module seq_alu #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] src0_i,
  input  logic [WIDTH-1:0] src1_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] dst_o,
  output logic [WIDTH-1:0] dst_h_o,
  output logic             div_zero_o,
  output logic             bad_op_o
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     dst_q, dst_d, dst_h_q, dst_h_d;
  logic                 dz_q, dz_d, bad_q, bad_d;
  logic [WIDTH:0]       add, sub, msum, diff;
  logic [2*WIDTH:0]     sh;
  logic [2*WIDTH-1:0]   mstep, dstep;
  logic [WIDTH-1:0]     imm_lo, imm_hi;
  logic                 imm_dz, imm_bad;
  assign add = {1'b0, src0_i} + {1'b0, src1_i};
  assign sub = {1'b0, src0_i} - {1'b0, src1_i};
  // p_q holds {accumulator, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  assign msum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : '0);
  assign mstep = {msum, p_q[WIDTH-1:1]};
  assign sh    = {p_q, 1'b0};
  assign diff  = sh[2*WIDTH:WIDTH] - {1'b0, b_q};
  assign dstep = {diff[WIDTH] ? sh[2*WIDTH-1:WIDTH] : diff[WIDTH-1:0], sh[WIDTH-1:1], ~diff[WIDTH]};
  always_comb begin
    imm_lo  = '0;
    imm_hi  = '0;
    imm_dz  = 1'b0;
    imm_bad = 1'b0;
    case (op_i)
      4'd0: begin
        imm_lo = src0_i;
        imm_hi = src1_i;
      end
      4'd1: {imm_hi, imm_lo} = {{(WIDTH-1){1'b0}}, add};
      4'd2: begin
        imm_lo = sub[WIDTH-1:0];
        imm_hi = {WIDTH{sub[WIDTH]}};
      end
      4'd4: begin
        imm_lo = '1;
        imm_hi = src0_i;
        imm_dz = 1'b1;
      end
      4'd5: imm_lo = src0_i >> src1_i;
      4'd6: imm_lo = src0_i << src1_i;
      4'd7: imm_lo = src0_i ^ src1_i;
      4'd8: imm_lo = src0_i & src1_i;
      4'd9: imm_lo = src0_i | src1_i;
      default: imm_bad = op_i > 4'd9;
    endcase
  end
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    dst_d   = dst_q;
    dst_h_d = dst_h_q;
    dz_d    = dz_q;
    bad_d   = bad_q;
    case (state_q)
      IDLE: if (start_i) begin
        p_d   = {{WIDTH{1'b0}}, op_i == 4'd3 ? src1_i : src0_i};
        b_d   = op_i == 4'd3 ? src0_i : src1_i;
        cnt_d = '0;
        if (op_i == 4'd3) state_d = MUL;
        else if (op_i == 4'd4 && |src1_i) state_d = DIV;
        else begin
          state_d = DONE;
          dst_d   = imm_lo;
          dst_h_d = imm_hi;
          dz_d    = imm_dz;
          bad_d   = imm_bad;
        end
      end
      MUL, DIV: begin
        p_d   = state_q == MUL ? mstep : dstep;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d            = DONE;
          {dst_h_d, dst_d}   = p_d;
          dz_d               = 1'b0;
          bad_d              = 1'b0;
        end
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      dst_q   <= '0;
      dst_h_q <= '0;
      dz_q    <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      dst_q   <= dst_d;
      dst_h_q <= dst_h_d;
      dz_q    <= dz_d;
      bad_q   <= bad_d;
    end
  end
  assign busy_o     = state_q != IDLE;
  assign done_o     = state_q == DONE;
  assign dst_o      = dst_q;
  assign dst_h_o    = dst_h_q;
  assign div_zero_o = dz_q;
  assign bad_op_o   = bad_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed checks of seq_alu at WIDTH=8 and WIDTH=32.
module tb_seq_alu;
  logic clk, rst;
  logic start8, busy8, done8, dz8, bad8;
  logic [3:0] op8;
  logic [7:0] a8, b8, dst8, dsth8;
  logic start32, busy32, done32, dz32, bad32;
  logic [3:0] op32;
  logic [31:0] a32, b32, dst32, dsth32;
  int checks = 0;
  int errors = 0;
  seq_alu #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start_i(start8), .op_i(op8), .src0_i(a8), .src1_i(b8),
    .busy_o(busy8), .done_o(done8), .dst_o(dst8), .dst_h_o(dsth8),
    .div_zero_o(dz8), .bad_op_o(bad8)
  );
  seq_alu #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .start_i(start32), .op_i(op32), .src0_i(a32), .src1_i(b32),
    .busy_o(busy32), .done_o(done32), .dst_o(dst32), .dst_h_o(dsth32),
    .div_zero_o(dz32), .bad_op_o(bad32)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // Issue one op and return at the first negedge where done is high; lat counts periods after the accepting edge.
  task automatic go8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, output int lat);
    @(negedge clk);
    op8 = op; a8 = a; b8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic go32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    op32 = op; a32 = a; b32 = b; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    lat = 1;
    while (!done32 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy8, done8, dz8, bad8, dst8, dsth8} !== 20'h0) begin
      errors++;
      $display("FAIL reset8: got %h expected 0", {busy8, done8, dz8, bad8, dst8, dsth8});
    end
    checks++;
    if ({busy32, done32, dz32, bad32, dst32, dsth32} !== 68'h0) begin
      errors++;
      $display("FAIL reset32: got %h expected 0", {busy32, done32, dz32, bad32, dst32, dsth32});
    end
    op32 = 4'd1; a32 = 32'd1; b32 = 32'd1; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    checks++;
    if ({busy32, done32} !== 2'b00) begin
      errors++;
      $display("FAIL rst_priority: got busy/done %b expected 00", {busy32, done32});
    end
    rst = 1'b0;
  endtask
  task automatic test_add;
    int lat;
    checks++;
    if (busy8 !== 1'b0) begin
      errors++;
      $display("FAIL add_idle_busy: got %b expected 0", busy8);
    end
    go8(4'd1, 8'hF0, 8'h20, lat);
    checks++;
    if (lat !== 1 || dst8 !== 8'h10 || dsth8 !== 8'h01 || busy8 !== 1'b1) begin
      errors++;
      $display("FAIL add8: got lat %0d dst %h dst_h %h busy %b expected lat 1 dst 10 dst_h 01 busy 1", lat, dst8, dsth8, busy8);
    end
    @(negedge clk);
    checks++;
    if ({busy8, done8} !== 2'b00 || dst8 !== 8'h10) begin
      errors++;
      $display("FAIL add8_after: got busy/done %b dst %h expected 00 dst 10", {busy8, done8}, dst8);
    end
  endtask
  task automatic test_single8;
    int lat;
    go8(4'd2, 8'h03, 8'h05, lat);
    checks++;
    if (lat !== 1 || dst8 !== 8'hFE || dsth8 !== 8'hFF) begin
      errors++;
      $display("FAIL sub8: got lat %0d dst %h dst_h %h expected lat 1 dst fe dst_h ff", lat, dst8, dsth8);
    end
    go8(4'd0, 8'hAA, 8'h55, lat);
    checks++;
    if (dst8 !== 8'hAA || dsth8 !== 8'h55) begin
      errors++;
      $display("FAIL mov8: got dst %h dst_h %h expected aa 55", dst8, dsth8);
    end
    go8(4'd6, 8'h81, 8'd9, lat);
    checks++;
    if (dst8 !== 8'h00 || dsth8 !== 8'h00) begin
      errors++;
      $display("FAIL shl8_over: got dst %h dst_h %h expected 00 00", dst8, dsth8);
    end
    go8(4'd6, 8'h81, 8'd1, lat);
    checks++;
    if (dst8 !== 8'h02) begin
      errors++;
      $display("FAIL shl8: got %h expected 02", dst8);
    end
    go8(4'd5, 8'h81, 8'd3, lat);
    checks++;
    if (dst8 !== 8'h10 || dsth8 !== 8'h00) begin
      errors++;
      $display("FAIL shr8: got dst %h dst_h %h expected 10 00", dst8, dsth8);
    end
    go8(4'd7, 8'hA5, 8'hFF, lat);
    checks++;
    if (dst8 !== 8'h5A) begin
      errors++;
      $display("FAIL xor8: got %h expected 5a", dst8);
    end
  endtask
  task automatic test_mul;
    int lat;
    go32(4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    checks++;
    if (lat !== 33 || dst32 !== 32'h00000001 || dsth32 !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL mul_max: got lat %0d dst %h dst_h %h expected lat 33 dst 00000001 dst_h fffffffe", lat, dst32, dsth32);
    end
    go32(4'd3, 32'h12345678, 32'd9, lat);
    checks++;
    if (lat !== 33 || dst32 !== 32'hA3D70A38 || dsth32 !== 32'h0) begin
      errors++;
      $display("FAIL mul_small: got lat %0d dst %h dst_h %h expected lat 33 dst a3d70a38 dst_h 0", lat, dst32, dsth32);
    end
  endtask
  task automatic test_div;
    int lat;
    go32(4'd4, 32'd100, 32'd7, lat);
    checks++;
    if (lat !== 33 || dst32 !== 32'd14 || dsth32 !== 32'd2 || dz32 !== 1'b0) begin
      errors++;
      $display("FAIL div_100_7: got lat %0d dst %0d dst_h %0d dz %b expected lat 33 dst 14 dst_h 2 dz 0", lat, dst32, dsth32, dz32);
    end
    go32(4'd4, 32'd100, 32'd0, lat);
    checks++;
    if (lat !== 1 || dst32 !== 32'hFFFFFFFF || dsth32 !== 32'd100 || dz32 !== 1'b1) begin
      errors++;
      $display("FAIL div_zero: got lat %0d dst %h dst_h %0d dz %b expected lat 1 dst ffffffff dst_h 100 dz 1", lat, dst32, dsth32, dz32);
    end
    go32(4'd8, 32'hF0F0F0F0, 32'hFF00FF00, lat);
    checks++;
    if (dst32 !== 32'hF000F000 || dsth32 !== 32'h0 || dz32 !== 1'b0) begin
      errors++;
      $display("FAIL and_after_dz: got dst %h dst_h %h dz %b expected f000f000 0 0", dst32, dsth32, dz32);
    end
    go32(4'd4, 32'd7, 32'd100, lat);
    checks++;
    if (dst32 !== 32'd0 || dsth32 !== 32'd7) begin
      errors++;
      $display("FAIL div_small: got dst %0d dst_h %0d expected 0 7", dst32, dsth32);
    end
    go32(4'd4, 32'hFFFFFFFF, 32'd1, lat);
    checks++;
    if (lat !== 33 || dst32 !== 32'hFFFFFFFF || dsth32 !== 32'd0) begin
      errors++;
      $display("FAIL div_by1: got lat %0d dst %h dst_h %h expected lat 33 dst ffffffff dst_h 0", lat, dst32, dsth32);
    end
  endtask
  task automatic test_ignored_start;
    int lat = 0;
    int ndone = 0;
    @(negedge clk);
    op32 = 4'd3; a32 = 32'd3; b32 = 32'd5; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (c == 10) begin
        op32 = 4'd1; a32 = 32'd1; b32 = 32'd1; start32 = 1'b1;
        checks++;
        if (busy32 !== 1'b1 || dst32 !== 32'hFFFFFFFF) begin
          errors++;
          $display("FAIL mul_busy_stable: got busy %b dst %h expected 1 ffffffff", busy32, dst32);
        end
      end
      if (c == 11) start32 = 1'b0;
      if (done32) begin
        ndone++;
        if (lat == 0) begin
          lat = c;
          checks++;
          if (dst32 !== 32'd15 || dsth32 !== 32'd0) begin
            errors++;
            $display("FAIL mul_ignore_result: got dst %0d dst_h %0d expected 15 0", dst32, dsth32);
          end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (lat !== 33 || ndone !== 1) begin
      errors++;
      $display("FAIL mul_ignore_done: got lat %0d pulses %0d expected lat 33 pulses 1", lat, ndone);
    end
  endtask
  task automatic test_rst_mid;
    int lat;
    int ndone = 0;
    @(negedge clk);
    op32 = 4'd4; a32 = 32'd1000; b32 = 32'd3; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy32, done32, dz32, bad32, dst32, dsth32} !== 68'h0) begin
      errors++;
      $display("FAIL rst_mid: got %h expected 0", {busy32, done32, dz32, bad32, dst32, dsth32});
    end
    for (int c = 0; c < 40; c++) begin
      if (done32) ndone++;
      @(negedge clk);
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL rst_mid_nodone: got %0d pulses expected 0", ndone);
    end
    go32(4'd1, 32'd5, 32'd6, lat);
    checks++;
    if (lat !== 1 || dst32 !== 32'd11 || dsth32 !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_add: got lat %0d dst %0d dst_h %0d expected 1 11 0", lat, dst32, dsth32);
    end
  endtask
  task automatic test_bad_op;
    int lat;
    go32(4'hC, 32'h1234, 32'h5678, lat);
    checks++;
    if (lat !== 1 || bad32 !== 1'b1 || dst32 !== 32'd0 || dsth32 !== 32'd0) begin
      errors++;
      $display("FAIL bad_op: got lat %0d bad %b dst %h dst_h %h expected 1 1 0 0", lat, bad32, dst32, dsth32);
    end
    go32(4'd9, 32'hF0, 32'h0F, lat);
    checks++;
    if (bad32 !== 1'b0 || dst32 !== 32'hFF) begin
      errors++;
      $display("FAIL bad_clear: got bad %b dst %h expected 0 ff", bad32, dst32);
    end
  endtask
  task automatic test_back_to_back;
    @(negedge clk);
    op8 = 4'd1; a8 = 8'd1; b8 = 8'd2; start8 = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 5) start8 = 1'b0;
      checks++;
      if (done8 !== (c % 2 == 1 && c <= 5) || (done8 && dst8 !== 8'd3)) begin
        errors++;
        $display("FAIL back_to_back c%0d: got done %b dst %0d expected done %b dst 3", c, done8, dst8, (c % 2 == 1 && c <= 5));
      end
    end
  endtask
  initial begin
    rst = 1'b1;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    test_reset;
    test_add;
    test_single8;
    test_mul;
    test_div;
    test_ignored_start;
    test_rst_mid;
    test_bad_op;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
